// File: rtl/sq_radix4_pipe.sv
// Pipelined radix-4 squarer with valid/ready flow control, selectable
// full/truncated result width and an optional running sum-of-squares mode.
//
// The operand is split into W/2 two-bit digits d_i. With X_i the value of the
// operand's low 2(i+1) bits:
//   X_i^2 = X_(i-1)^2 + d_i*4^i * (d_i*4^i + 2*X_(i-1))
// so the square is the sum of W/2 partial squares, one per digit. Stage 1
// forms them, the middle stages halve the term count pairwise, and the final
// stage adds what is left plus the accumulator. All term arithmetic is done
// modulo 2^OW, which is exact for the truncated result and for the full one.
module sq_radix4_pipe #(
  parameter int W      = 16,
  parameter int STAGES = 2,
  parameter int FULL   = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [W-1:0]                        in_data,
  input  logic                                in_acc,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [((FULL != 0) ? 2*W : W)-1:0]  out_data,
  output logic                                out_ovf
);

  localparam int OW = (FULL != 0) ? 2*W : W;
  localparam int N  = W / 2;

  typedef logic [OW-1:0]         term_t;
  typedef logic [N-1:0][OW-1:0]  terms_t;

  // One partial square per radix-4 digit: d_i * 4^i * (d_i*4^i + 2*low_i),
  // where low_i is the operand below digit i.
  function automatic terms_t form_partials(input logic [W-1:0] x);
    terms_t p;
    term_t  low;
    term_t  base;
    for (int i = 0; i < N; i++) begin
      low = '0;
      for (int b = 0; b < 2*i; b++) low[b] = x[b];
      base = (term_t'(x[2*i +: 2]) << (2*i)) + (low << 1);
      case (x[2*i +: 2])
        2'd0:    p[i] = '0;
        2'd1:    p[i] = base << (2*i);
        2'd2:    p[i] = base << (2*i + 1);
        default: p[i] = (base + (base << 1)) << (2*i);
      endcase
    end
    return p;
  endfunction

  // Pairwise reduction: term j lands in slot j/2, upper slots become zero.
  function automatic terms_t reduce_pairs(input terms_t t);
    terms_t r;
    r = '0;
    for (int j = 0; j < N; j++) r[j/2] = r[j/2] + t[j];
    return r;
  endfunction

  function automatic term_t sum_terms(input terms_t t);
    term_t s;
    s = '0;
    for (int j = 0; j < N; j++) s = s + t[j];
    return s;
  endfunction

  // Global stall: the whole pipe moves only when the output slot frees up.
  logic  advance;
  logic  ready_en;
  logic  accept;
  logic  fin_valid;
  logic  fin_load;
  logic  fin_acc;
  term_t fin_sq;
  term_t acc_q;
  term_t acc_term;
  logic [OW:0] total_sum;

  assign advance  = !out_valid || out_ready;
  assign in_ready = ready_en && advance;
  assign accept   = in_valid && in_ready;
  assign fin_load = advance && fin_valid;

  if (STAGES == 1) begin : g_single
    // The only register is the output stage: square and accumulate in one go.
    assign fin_valid = accept;
    assign fin_sq    = sum_terms(form_partials(in_data));
    assign fin_acc   = in_acc;
  end else begin : g_multi
    localparam int NT = STAGES - 1;

    terms_t st_terms [NT];
    logic   st_acc   [NT];
    logic   st_valid [NT];

    // Slot occupancy: bubbles and operands shift together on every advance.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < NT; s++) st_valid[s] <= 1'b0;
      end else if (advance) begin
        st_valid[0] <= accept;
        for (int s = 1; s < NT; s++) st_valid[s] <= st_valid[s-1];
      end
    end

    // Term stages: form partial squares, then halve the term count per stage.
    // NOTE: datapath stage registers carry no reset; their contents only
    // matter while the matching valid bit is set.
    always_ff @(posedge clk) begin
      if (advance) begin
        st_terms[0] <= form_partials(in_data);
        st_acc[0]   <= in_acc;
        for (int s = 1; s < NT; s++) begin
          st_terms[s] <= reduce_pairs(st_terms[s-1]);
          st_acc[s]   <= st_acc[s-1];
        end
      end
    end

    assign fin_valid = st_valid[NT-1];
    assign fin_sq    = sum_terms(st_terms[NT-1]);
    assign fin_acc   = st_acc[NT-1];
  end

  // Final add is modulo 2^OW; its carry out becomes the overflow flag.
  assign acc_term  = fin_acc ? acc_q : '0;
  assign total_sum = {1'b0, fin_sq} + {1'b0, acc_term};

  // Output slot, overflow flag and running accumulator. The accumulator moves
  // only when a valid entry lands in the output slot, so it follows the
  // acceptance order of operands.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      acc_q     <= '0;
    end else begin
      ready_en <= 1'b1;
      if (advance) out_valid <= fin_valid;
      if (fin_load) begin
        out_data <= total_sum[OW-1:0];
        out_ovf  <= total_sum[OW];
        acc_q    <= total_sum[OW-1:0];
      end
    end
  end

endmodule
